player_input_cond: RTL and testbench
====================================

Name: player_input_cond

Overview:
- Input conditioning stage for the tug-of-war playfield. Sits directly upstream of the light-chain and victory logic.
- Takes the two raw, asynchronous, active-low player pushbuttons, then synchronizes and debounces them.
- Emits exactly one single-cycle press pulse (L, R) per physical press, which the center/normal lights and victory detector consume.
- Also reports debounced held levels and suppresses pulses while the game is frozen.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per button (legal values 2 or more).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a press or a release (legal values 1 or more; board build overrides to roughly 1 ms worth of clocks).

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- key_l_n  input  1  raw left-player button, active-low, asynchronous to clk.
- key_r_n  input  1  raw right-player button, active-low, asynchronous to clk.
- enable  input  1  synchronous; when 0 (game over/frozen), no pulses are emitted.
- L  output  1  one-cycle left press pulse, registered.
- R  output  1  one-cycle right press pulse, registered.
- held_l  output  1  debounced left pressed level, registered.
- held_r  output  1  debounced right pressed level, registered.

Behaviour:
- Reset, asynchronous while low:
  - L=0, R=0, held_l=0, held_r=0.
  - Synchronizer flops load 1 (released).
  - Both FSMs go to IDLE; counters are 0.
  - Reset asserted mid-count or mid-pulse aborts immediately. No pulse is produced after reset deasserts unless a fresh full debounce completes.
- Synchronizer:
  - SYNC_STAGES-flop chain per key.
  - s = inverted chain output, so s=1 means pressed.
- Per-channel FSM (identical, independent):
  - States: IDLE, PRESS_WAIT, HELD, REL_WAIT.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - IDLE: on an edge with s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT, s=0: go to IDLE, cnt=0 (glitch rejected).
  - PRESS_WAIT, s=1 and cnt<DEBOUNCE_CYCLES: cnt++.
  - PRESS_WAIT, s=1 and cnt==DEBOUNCE_CYCLES: go to HELD, held=1, pulse=enable.
  - HELD: on s=0, go to REL_WAIT with cnt=1.
  - REL_WAIT, s=1: go to HELD, cnt=0.
  - REL_WAIT, s=0 and cnt<DEBOUNCE_CYCLES: cnt++.
  - REL_WAIT, s=0 and cnt==DEBOUNCE_CYCLES: go to IDLE, held=0.
- Latency:
  - Let E0 be the first clk edge that samples the raw key low, with the key held stable from then on.
  - L/R goes high after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES.
  - It stays high for exactly one cycle.
  - held_x rises on the same edge as the pulse.
- Pulse rules:
  - A key held indefinitely gives one pulse only.
  - A new pulse requires a debounced release (return to IDLE) followed by a full new press debounce.
- enable:
  - Sampled only at the HELD-entry edge. If enable=0 there, no pulse is emitted and none is produced later for that press.
  - held_x and the FSM are unaffected by enable.
- Simultaneous presses:
  - Channels are independent; L and R may both be 1 in the same cycle.
  - Downstream logic treats L&R as no move.
- No combinational path from any input to any output.

Decomposition:
- Shared package tug_pkg holds:
  - the typedef enum for debounce states {IDLE, PRESS_WAIT, HELD, REL_WAIT};
  - the default DEBOUNCE_CYCLES and SYNC_STAGES constants, reused by board top and benches.
- One sub-module, key_debounce: synchronizer plus FSM plus counter for one key, with pulse and held outputs.
- player_input_cond instantiates key_debounce twice and gates the pulses with enable.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset low 3 cycles, keys high -> all outputs 0. Release reset, key_l_n low from E0 -> L=1 only in the cycle after E6, held_l=1 from E6. Hold key 20 cycles -> no further L.
- key_r_n low 2 cycles, then high, twice -> R never asserts, held_r stays 0.
- Press L (pulse seen), release 2 cycles, press again -> no second pulse (release not debounced). Release 6 or more cycles, then press -> second L pulse exactly 6 edges after the re-press is sampled.
- key_l_n and key_r_n fall on the same edge -> L=1 and R=1 in the same cycle.
- enable=0 during a press -> held_l=1, L stays 0. Set enable=1 while still held -> L stays 0.
- Reset asserted asynchronously mid-PRESS_WAIT, at cnt=3 -> outputs clear immediately. Key still low after reset release -> pulse after a full 2+4 edges from release, not earlier.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared tug-of-war types and defaults.
// Debounce state encoding and build constants reused by tops and benches.
package tug_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } deb_state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/player_input_cond_if.sv
// Player key / press-pulse bundle.
// master: drives keys and enable; slave: returns pulses and held levels.
interface player_input_cond_if;

  logic key_l_n;
  logic key_r_n;
  logic enable;
  logic L;
  logic R;
  logic held_l;
  logic held_r;

  modport master (
    output key_l_n,
    output key_r_n,
    output enable,
    input  L,
    input  R,
    input  held_l,
    input  held_r
  );

  modport slave (
    input  key_l_n,
    input  key_r_n,
    input  enable,
    output L,
    output R,
    output held_l,
    output held_r
  );

endinterface

// File: rtl/key_debounce.sv
// One-key synchronizer + debounce FSM.
// Ports: clk, reset (async low), key_n raw; press = HELD-entry strobe, held level.
module key_debounce
  import tug_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press,
  output logic held
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DC  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  deb_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          held_q, held_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
    end
  end

  // Chain output is active-low; s=1 means pressed.
  assign s = ~sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      held_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      held_q <= held_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    held_nx  = held_q;
    press    = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt < DC) begin
          cnt_nx = cnt + ONE;
        end else begin
          state_nx = HELD;
          cnt_nx   = '0;
          held_nx  = 1'b1;
          press    = 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_nx = REL_WAIT;
          cnt_nx   = ONE;
        end
      end
      REL_WAIT: begin
        if (s) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt < DC) begin
          cnt_nx = cnt + ONE;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
          held_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        held_nx  = 1'b0;
      end
    endcase
  end

  assign held = held_q;

endmodule

// File: rtl/player_input_cond.sv
// Tug-of-war input conditioning: two debounced keys, one pulse per press.
// Ports: clk, reset (async low), bus (slave: keys/enable in, L/R/held out).
module player_input_cond
  import tug_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  player_input_cond_if.slave  bus
);

  logic press_l, press_r;
  logic held_l, held_r;
  logic l_q, r_q;

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_l (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_l_n),
    .press (press_l),
    .held  (held_l)
  );

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_r (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_r_n),
    .press (press_r),
    .held  (held_r)
  );

  // enable only matters on the HELD-entry edge; a frozen press is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      l_q <= press_l & bus.enable;
      r_q <= press_r & bus.enable;
    end
  end

  assign bus.L      = l_q;
  assign bus.R      = r_q;
  assign bus.held_l = held_l;
  assign bus.held_r = held_r;

endmodule

// File: tb/tb_player_input_cond.sv
// Directed bench for player_input_cond (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Hand-computed latencies: pulse after edge E0+6, held from the same edge.
module tb_player_input_cond;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  player_input_cond_if bus();

  player_input_cond #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [3:0] outs();
    return {bus.L, bus.R, bus.held_l, bus.held_r};
  endfunction

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b0;
    bus.key_l_n = 1'b1;
    bus.key_r_n = 1'b1;
    bus.enable  = 1'b1;

    // Reset state
    idle(3);
    chk("reset_outs", 32'(outs()), 32'h0);
    reset = 1'b1;
    tick();

    // Basic left press, latency and single pulse
    bus.key_l_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("l1_L_%0d", i), 32'(bus.L), 32'(i == 7));
      chk($sformatf("l1_held_%0d", i), 32'(bus.held_l), 32'(i >= 7));
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("l1_hold_L_%0d", i), 32'(bus.L), 32'h0);
    end
    chk("l1_hold_held", 32'(bus.held_l), 32'h1);
    bus.key_l_n = 1'b1;
    idle(10);
    chk("l1_released", 32'(outs()), 32'h0);

    // Right glitches rejected
    for (int k = 0; k < 2; k++) begin
      bus.key_r_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tick();
        chk($sformatf("glitch_%0d_%0d", k, i), 32'(outs()), 32'h0);
      end
      bus.key_r_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk($sformatf("glitch_%0d_r%0d", k, i), 32'(outs()), 32'h0);
      end
    end

    // Short release is not a new press
    bus.key_l_n = 1'b0;
    idle(6);
    tick();
    chk("l2_pulse", 32'(bus.L), 32'h1);
    bus.key_l_n = 1'b1;
    idle(2);
    bus.key_l_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("l2_nopulse_%0d", i), 32'(bus.L), 32'h0);
    end
    chk("l2_still_held", 32'(bus.held_l), 32'h1);
    bus.key_l_n = 1'b1;
    idle(8);
    chk("l2_rel_held", 32'(bus.held_l), 32'h0);
    bus.key_l_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("l3_L_%0d", i), 32'(bus.L), 32'(i == 7));
    end
    bus.key_l_n = 1'b1;
    idle(10);

    // Simultaneous presses
    bus.key_l_n = 1'b0;
    bus.key_r_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("lr_%0d", i), 32'(outs()),
          (i == 7) ? 32'hF : (i > 7) ? 32'h3 : 32'h0);
    end
    bus.key_l_n = 1'b1;
    bus.key_r_n = 1'b1;
    idle(10);
    chk("lr_released", 32'(outs()), 32'h0);

    // Frozen game: held follows the key, no pulse ever
    bus.enable  = 1'b0;
    bus.key_l_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("en0_L_%0d", i), 32'(bus.L), 32'h0);
    end
    chk("en0_held", 32'(bus.held_l), 32'h1);
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en1_L_%0d", i), 32'(bus.L), 32'h0);
    end
    bus.key_l_n = 1'b1;
    idle(10);

    // Async reset clears held immediately
    bus.key_l_n = 1'b0;
    idle(9);
    chk("ar_pre_held", 32'(bus.held_l), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_held_clear", 32'(outs()), 32'h0);
    bus.key_l_n = 1'b1;
    tick();
    reset = 1'b1;
    idle(3);

    // Async reset mid PRESS_WAIT (cnt=3), key kept low through it
    bus.key_l_n = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("pw_%0d", i), 32'(outs()), 32'h0);
    end
    #3;
    reset = 1'b0;
    #1;
    chk("pw_reset_outs", 32'(outs()), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("pw_post_L_%0d", i), 32'(bus.L), 32'(i == 7));
      chk($sformatf("pw_post_held_%0d", i), 32'(bus.held_l), 32'(i >= 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
